// File: rtl/pcm_sync_pkg.sv
// Shared definitions for the PCM frame synchronizer: sync state encodings,
// default sync word width, payload byte width and small helpers.
package pcm_sync_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'b00,
    ST_CHECK  = 2'b01,
    ST_LOCK   = 2'b10
  } sync_state_e;

  localparam int SYNC_W_DEFAULT = 32;
  localparam int BYTE_W         = 8;

  // A programmed frame count of zero behaves like one.
  function automatic logic [3:0] cnt_eff(input logic [3:0] cnt);
    return (cnt == 4'd0) ? 4'd1 : cnt;
  endfunction

endpackage

// File: rtl/pcm_frame_sync_if.sv
// Frame write path from the synchronizer to the frame-head timestamp
// inserter: frame-head pulse plus payload byte with its write strobe.
interface pcm_frame_sync_if;
  import pcm_sync_pkg::*;

  logic              start_o;
  logic [BYTE_W-1:0] wr_data_o;
  logic              wr_req_o;

  modport master (output start_o, output wr_data_o, output wr_req_o);
  modport slave  (input  start_o, input  wr_data_o, input  wr_req_o);

endinterface

// File: rtl/pcm_sync_corr.sv
// Registered sync word correlator: match_o is high one clock after sreg_i
// lies within the allowed Hamming distance of sync_word_i.
// Build option PCM_SYNC_ERRTOL_EN: when defined the tolerance is tol_i and a
// popcount of the difference is built; otherwise only an exact compare exists.
module pcm_sync_corr
  import pcm_sync_pkg::*;
#(
  parameter int SYNC_W = SYNC_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [SYNC_W-1:0] sreg_i,
  input  logic [SYNC_W-1:0] sync_word_i,
  input  logic [2:0]        tol_i,
  output logic              match_o
);

  logic match_d;
  logic match_q;

`ifdef PCM_SYNC_ERRTOL_EN
  localparam int DIST_W = $clog2(SYNC_W + 1);

  function automatic logic [DIST_W-1:0] popcount(input logic [SYNC_W-1:0] v);
    logic [DIST_W-1:0] n;
    n = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      n = n + DIST_W'(v[i]);
    end
    return n;
  endfunction

  // Tolerant compare: count differing bits and compare against the tolerance.
  always_comb begin
    match_d = (popcount(sreg_i ^ sync_word_i) <= DIST_W'(tol_i));
  end
`else
  logic unused_tol;
  assign unused_tol = ^tol_i;

  // Exact compare only; the tolerance input has no effect in this build.
  always_comb begin
    match_d = (sreg_i == sync_word_i);
  end
`endif

  // Register the compare result so the decision sees a stable match.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/pcm_frame_sync.sv
// Serial PCM frame synchronizer: search, confirm and lock onto the frame
// sync word, emit a frame-head pulse and pack payload bits into bytes.
// Build option PCM_SYNC_ERRTOL_EN (inside pcm_sync_corr) enables the
// bit-error tolerant sync compare; without it the compare is exact.
module pcm_frame_sync
  import pcm_sync_pkg::*;
#(
  parameter int SYNC_W = SYNC_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  bit_i,
  input  logic                  bit_valid_i,
  input  logic [SYNC_W-1:0]     sync_word_i,
  input  logic [CNT_W-1:0]      frame_len_i,
  input  logic [2:0]            err_tol_i,
  input  logic [3:0]            check_cnt_i,
  input  logic [3:0]            lose_cnt_i,
  pcm_frame_sync_if.master      wr_if,
  output logic                  lock_o,
  output logic [1:0]            sync_state_o
);

  localparam int                  BIT_IDX_W = $clog2(BYTE_W);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0]     SYNC_LEN = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0]     BCNT_MAX = '1;

  sync_state_e          state_q, state_d;
  logic [SYNC_W-1:0]    sreg_q, sreg_d;
  logic [CNT_W-1:0]     bcnt_q, bcnt_d, bcnt_base;
  logic [CNT_W-1:0]     frame_len_q, frame_len_d;
  logic                 strb1_q, strb1_d;
  logic                 strb2_q, strb2_d;
  logic [3:0]           hits_q, hits_d;
  logic [3:0]           misses_q, misses_d;
  logic                 start_q, start_d;
  logic [BYTE_W-1:0]    byte_q, byte_d;
  logic [BIT_IDX_W-1:0] bitcnt_q, bitcnt_d;
  logic                 byte_rdy_q, byte_rdy_d;
  logic                 wr_req_q, wr_req_d;
  logic [BYTE_W-1:0]    wr_data_q, wr_data_d;

  logic match;
  logic hit;
  logic exp_bnd;
  logic bnd_acc;
  logic pay_bit;

  // strb1 marks the cycle after a strobe (sreg/bcnt hold the new bit),
  // strb2 the cycle after that, when the registered match is available.
  pcm_sync_corr #(.SYNC_W(SYNC_W)) u_corr (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .sreg_i      (sreg_q),
    .sync_word_i (sync_word_i),
    .tol_i       (err_tol_i),
    .match_o     (match)
  );

  // No strobe can land on the strb1 cycle, so bcnt_q still reflects the
  // strobe under decision while strb2 is high.
  assign hit     = strb2_q && match;
  assign exp_bnd = strb2_q && (bcnt_q == frame_len_q);

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state with hit/miss bookkeeping and boundary acceptance.
  always_comb begin
    state_d  = state_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    bnd_acc  = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (hit) begin
          bnd_acc = 1'b1;
          hits_d  = 4'd1;
          if (4'd1 >= cnt_eff(check_cnt_i)) begin
            state_d  = ST_LOCK;
            misses_d = 4'd0;
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (exp_bnd) begin
          if (match) begin
            bnd_acc = 1'b1;
            hits_d  = hits_q + 4'd1;
            if ((hits_q + 4'd1) >= cnt_eff(check_cnt_i)) begin
              state_d  = ST_LOCK;
              misses_d = 4'd0;
            end
          end else begin
            state_d = ST_SEARCH;
            hits_d  = 4'd0;
          end
        end
      end
      ST_LOCK: begin
        if (exp_bnd) begin
          bnd_acc = 1'b1;
          if (match) begin
            misses_d = 4'd0;
          end else if ((misses_q + 4'd1) >= cnt_eff(lose_cnt_i)) begin
            state_d  = ST_SEARCH;
            misses_d = 4'd0;
            hits_d   = 4'd0;
          end else begin
            misses_d = misses_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
      end
    endcase
  end

  // FSM outputs: frame head on every accepted boundary that ends in LOCK
  // (entry, good sync or flywheel); none when LOCK is being dropped.
  always_comb begin
    start_d = bnd_acc && (state_d == ST_LOCK);
  end

  assign lock_o       = (state_q == ST_LOCK);
  assign sync_state_o = state_q;

  // Bit shift register, saturating bit counter, strobe delay line and
  // frame length captured at each accepted boundary.
  always_comb begin
    sreg_d      = bit_valid_i ? {sreg_q[SYNC_W-2:0], bit_i} : sreg_q;
    bcnt_base   = bnd_acc ? '0 : bcnt_q;
    bcnt_d      = (bit_valid_i && (bcnt_base != BCNT_MAX)) ? bcnt_base + CNT_W'(1) : bcnt_base;
    frame_len_d = bnd_acc ? frame_len_i : frame_len_q;
    strb1_d     = bit_valid_i;
    strb2_d     = strb1_q;
  end

  // Payload byte packer: bits 1 .. frame_len - SYNC_W after a boundary,
  // MSB first; a partial byte is dropped at boundaries and on leaving LOCK.
  always_comb begin
    pay_bit    = strb1_q && (state_q == ST_LOCK) && (bcnt_q != '0) &&
                 (bcnt_q <= (frame_len_q - SYNC_LEN));
    byte_d     = byte_q;
    bitcnt_d   = bitcnt_q;
    byte_rdy_d = 1'b0;
    if (bnd_acc || (state_d != ST_LOCK)) begin
      bitcnt_d = '0;
    end else if (pay_bit) begin
      byte_d     = {byte_q[BYTE_W-2:0], sreg_q[0]};
      bitcnt_d   = bitcnt_q + BIT_IDX_W'(1);
      byte_rdy_d = (bitcnt_q == LAST_BIT);
    end
    wr_req_d  = byte_rdy_q;
    wr_data_d = byte_rdy_q ? byte_q : wr_data_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sreg_q      <= '0;
      bcnt_q      <= '0;
      frame_len_q <= '0;
      strb1_q     <= 1'b0;
      strb2_q     <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
      start_q     <= 1'b0;
      byte_q      <= '0;
      bitcnt_q    <= '0;
      byte_rdy_q  <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_data_q   <= '1;
    end else begin
      sreg_q      <= sreg_d;
      bcnt_q      <= bcnt_d;
      frame_len_q <= frame_len_d;
      strb1_q     <= strb1_d;
      strb2_q     <= strb2_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      start_q     <= start_d;
      byte_q      <= byte_d;
      bitcnt_q    <= bitcnt_d;
      byte_rdy_q  <= byte_rdy_d;
      wr_req_q    <= wr_req_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_if.start_o   = start_q;
  assign wr_if.wr_req_o  = wr_req_q;
  assign wr_if.wr_data_o = wr_data_q;

endmodule

// File: tb/tb_pcm_frame_sync.sv
// Directed bench for pcm_frame_sync: acquisition, payload bytes, error
// tolerance, flywheel/loss, CHECK failure and mid-frame reset.
module tb_pcm_frame_sync;

  localparam logic [31:0] SYNC = 32'hEB90_146F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_v;
  logic [31:0] sync_word;
  logic [15:0] frame_len;
  logic [2:0]  err_tol;
  logic [3:0]  check_cnt;
  logic [3:0]  lose_cnt;
  logic        lock;
  logic [1:0]  state;

  pcm_frame_sync_if wr_if ();

  pcm_frame_sync #(.SYNC_W(32), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .bit_i        (bit_in),
    .bit_valid_i  (bit_v),
    .sync_word_i  (sync_word),
    .frame_len_i  (frame_len),
    .err_tol_i    (err_tol),
    .check_cnt_i  (check_cnt),
    .lose_cnt_i   (lose_cnt),
    .wr_if        (wr_if),
    .lock_o       (lock),
    .sync_state_o (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_start = 0;
  int n_wr = 0;
  int start_cyc = 0;
  logic [7:0] wr_q[$];
  int wr_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_if.start_o) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
    end
    if (wr_if.wr_req_o) begin
      wr_q.push_back(wr_if.wr_data_o);
      wr_cyc_q.push_back(cyc);
      n_wr <= n_wr + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int last_edge = 0;
  int sync_edge = 0;
  int first_edge = 0;
  int snap = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in = b;
    bit_v  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_edge = cyc;
    bit_v = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_sync(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
    sync_edge = last_edge;
  endtask

  task automatic send_payload(input logic [7:0] base, input int nbytes);
    logic [7:0] v;
    for (int b = 0; b < nbytes; b++) begin
      v = base + 8'(b);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      if (b == 0) first_edge = last_edge;
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
  endtask

  task automatic frame(input logic [31:0] w, input logic [7:0] base);
    send_sync(w);
    send_payload(base, 28);
    settle();
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_start"},   32'(wr_if.start_o),   32'd0);
    chk({tag, "_wr_req"},  32'(wr_if.wr_req_o),  32'd0);
    chk({tag, "_wr_data"}, 32'(wr_if.wr_data_o), 32'hFF);
    chk({tag, "_lock"},    32'(lock),            32'd0);
    chk({tag, "_state"},   32'(state),           32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bit_in    = 1'b0;
    bit_v     = 1'b0;
    sync_word = SYNC;
    frame_len = 16'd256;
    err_tol   = 3'd0;
    check_cnt = 4'd3;
    lose_cnt  = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Acquisition: two confirming frames in SEARCH/CHECK, no output.
    frame(SYNC, 8'h80);
    chk("f1_state", 32'(state), 32'd1);
    chk("f1_start", n_start, 0);
    chk("f1_wr", n_wr, 0);
    frame(SYNC, 8'hA0);
    chk("f2_state", 32'(state), 32'd1);
    chk("f2_start", n_start, 0);
    chk("f2_wr", n_wr, 0);

    // Third sync locks; payload 00..1B comes out in order.
    clear_log();
    frame(SYNC, 8'h00);
    chk("f3_state", 32'(state), 32'd2);
    chk("f3_lock", 32'(lock), 32'd1);
    chk("f3_start", n_start, 1);
    chk("f3_start_lat", start_cyc - sync_edge, 2);
    chk("f3_nbytes", wr_q.size(), 28);
    for (int i = 0; i < 28; i++)
      chk("f3_byte", (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hDEAD, 32'(i));
    chk("f3_byte_lat", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - first_edge : -1, 2);

    // Locked frame: one start per frame, 28 bytes.
    clear_log();
    frame(SYNC, 8'h40);
    chk("f4_start", n_start, 2);
    chk("f4_start_lat", start_cyc - sync_edge, 2);
    chk("f4_nbytes", wr_q.size(), 28);
    chk("f4_first", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD, 32'h40);
    chk("f4_last", (wr_q.size() > 27) ? 32'(wr_q[27]) : 32'hDEAD, 32'h5B);

    // Two flipped sync bits with tolerance 2: accepted (or flywheel).
    clear_log();
    err_tol = 3'd2;
    send_sync(SYNC ^ 32'h0001_0100);
    err_tol = 3'd0;
    send_payload(8'h60, 28);
    settle();
    chk("f5_start", n_start, 3);
    chk("f5_start_lat", start_cyc - sync_edge, 2);
    chk("f5_lock", 32'(lock), 32'd1);
    chk("f5_nbytes", wr_q.size(), 28);

    // Fully wrong sync: flywheel if the previous one counted as a hit,
    // loss of lock if it already counted as a miss.
    clear_log();
    frame(~SYNC, 8'h20);
`ifdef PCM_SYNC_ERRTOL_EN
    chk("f6_start", n_start, 4);
    chk("f6_lock", 32'(lock), 32'd1);
    chk("f6_nbytes", wr_q.size(), 28);
`else
    chk("f6_start", n_start, 3);
    chk("f6_lock", 32'(lock), 32'd0);
    chk("f6_state", 32'(state), 32'd0);
    chk("f6_nbytes", wr_q.size(), 0);
`endif

    // Second consecutive miss (or still searching): SEARCH, silent.
    snap = n_start;
    clear_log();
    frame(~SYNC, 8'hC0);
    chk("f7_state", 32'(state), 32'd0);
    chk("f7_lock", 32'(lock), 32'd0);
    chk("f7_start", n_start, snap);
    chk("f7_nbytes", wr_q.size(), 0);

    // CHECK failure: good sync then wrong sync returns to SEARCH.
    frame(SYNC, 8'h10);
    chk("f8_state", 32'(state), 32'd1);
    frame(~SYNC, 8'h30);
    chk("f9_state", 32'(state), 32'd0);
    chk("f9_start", n_start, snap);
    chk("f9_nbytes", wr_q.size(), 0);

    // Reacquire over three frames.
    frame(SYNC, 8'h00);
    chk("f10_state", 32'(state), 32'd1);
    frame(SYNC, 8'h00);
    chk("f11_state", 32'(state), 32'd1);
    clear_log();
    frame(SYNC, 8'h00);
    chk("f12_state", 32'(state), 32'd2);
    chk("f12_start", n_start, snap + 1);
    chk("f12_start_lat", start_cyc - sync_edge, 2);
    chk("f12_nbytes", wr_q.size(), 28);

    // Reset right after the second byte's last bit, while it is in flight.
    clear_log();
    send_sync(SYNC);
    send_payload(8'h50, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_outputs_reset("midrst");
    repeat (4) @(posedge clk);
    chk("midrst_nbytes", wr_q.size(), 1);
    chk("midrst_byte0", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD, 32'h50);
    @(negedge clk);
    rst_n = 1'b1;
    snap = n_start;

    // Reacquisition after reset takes check_cnt frames.
    clear_log();
    frame(SYNC, 8'h00);
    chk("f14_state", 32'(state), 32'd1);
    frame(SYNC, 8'h00);
    chk("f15_state", 32'(state), 32'd1);
    chk("f15_nbytes", wr_q.size(), 0);
    chk("f15_start", n_start, snap);
    frame(SYNC, 8'h70);
    chk("f16_state", 32'(state), 32'd2);
    chk("f16_start", n_start, snap + 1);
    chk("f16_nbytes", wr_q.size(), 28);
    chk("f16_first", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hDEAD, 32'h70);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
